spi_conf_regfile: RTL

//  Parametrised ARM->FPGA SPI configuration receiver; successor to the fixed 16-bit conf_word/divisor shifter.

---
 rtl/spi_conf_regfile_pkg.sv | 24 ++
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_conf_regfile.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/spi_conf_regfile_pkg.sv
// Shared command codes, mode codes and frame FSM state type for the SPI
// configuration receiver.
package spi_conf_regfile_pkg;

  // Command codes sent by the ARM in the top nibble of each frame
  localparam int FPGA_CMD_NOP         = 0;
  localparam int FPGA_CMD_SET_CONFREG = 1;
  localparam int FPGA_CMD_SET_DIVISOR = 2;
  localparam int FPGA_CMD_READ_BASE   = 8;

  // Major-mode codes carried in the top bits of the conf word
  localparam logic [2:0] MODE_LF_READER = 3'b000;
  localparam logic [2:0] MODE_OFF       = 3'b111;

  // The ARM firmware always clocks 16-bit frames; any gap between the command
  // field and the data field is padding.
  localparam int LEGACY_FRAME_W = 16;

  typedef enum logic {
    FRAME_IDLE,
    FRAME_ACTIVE
  } frame_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for one asynchronous SPI pin, followed by registered
// rise/fall pulse detection. Pin-to-pulse latency is three clock cycles.
module spi_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync_q;
  logic prev;

  // Bring the pin into the clock domain and register one-cycle edge pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      meta   <= 1'b0;
      sync_q <= 1'b0;
      prev   <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      meta   <= din;
      sync_q <= meta;
      prev   <= sync_q;
      rise   <= sync_q & ~prev;
      fall   <= ~sync_q & prev;
    end
  end

endmodule

// File: rtl/spi_conf_regfile.sv
// ARM->FPGA SPI configuration receiver: oversampled SPI slave that writes the
// config register file, supports readback over miso, counts bad-length frames
// and commits the major mode only when the carrier can switch cleanly.
module spi_conf_regfile
  import spi_conf_regfile_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                CMD_W    = 4,
  parameter int                NUM_REGS = 2,
  parameter int                MODE_W   = 3,
  parameter int                RD_BASE  = FPGA_CMD_READ_BASE,
  parameter logic [DATA_W-1:0] REG0_RST = 8'hE0,
  parameter int                FRAME_W  = LEGACY_FRAME_W
) (
  input  logic                         ck_1356meg,
  input  logic                         reset,
  input  logic                         spck,
  input  logic                         ncs,
  input  logic                         mosi,
  output logic                         miso,
  input  logic                         mode_safe,
  output logic [NUM_REGS*DATA_W-1:0]   regs,
  output logic [MODE_W-1:0]            major_mode,
  output logic                         mode_pending,
  output logic                         mode_changed,
  output logic [NUM_REGS-1:0]          wr_strobe,
  output logic [7:0]                   frame_err_cnt
);

  localparam int CNT_W = $clog2(FRAME_W + 2);
  localparam int PAD_W = FRAME_W - CMD_W - DATA_W;

  logic spck_rise, spck_fall, ncs_rise, ncs_fall;
  logic mosi_meta, mosi_sync;

  frame_state_t state, state_next;
  logic start_frame, end_good, end_bad, take_bit, give_bit;
  logic reg0_write;

  logic [FRAME_W-1:0] shift, tx, rd_latch;
  logic [CNT_W-1:0]   bit_cnt;
  logic [DATA_W-1:0]  reg_q [NUM_REGS];
  logic [MODE_W-1:0]  pending_mode;
  logic [CMD_W-1:0]   cmd;
  logic [DATA_W-1:0]  dat;

  spi_sync_edge u_spck_sync (
    .clk   (ck_1356meg),
    .reset (reset),
    .din   (spck),
    .rise  (spck_rise),
    .fall  (spck_fall)
  );

  spi_sync_edge u_ncs_sync (
    .clk   (ck_1356meg),
    .reset (reset),
    .din   (ncs),
    .rise  (ncs_rise),
    .fall  (ncs_fall)
  );

  // mosi only needs a clean level; it is stable for several cycles around spck rise
  always_ff @(posedge ck_1356meg) begin
    if (reset) begin
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
    end else begin
      mosi_meta <= mosi;
      mosi_sync <= mosi_meta;
    end
  end

  assign cmd        = shift[FRAME_W-1 -: CMD_W];
  assign dat        = shift[DATA_W-1:0];
  assign reg0_write = end_good && (cmd == CMD_W'(FPGA_CMD_SET_CONFREG));

  // Frame state register; a frame open at reset release stays ignored until ncs rises
  always_ff @(posedge ck_1356meg) begin
    if (reset) state <= FRAME_IDLE;
    else       state <= state_next;
  end

  // Chip select alone moves the frame state
  always_comb begin
    state_next = state;
    if (ncs_fall)      state_next = FRAME_ACTIVE;
    else if (ncs_rise) state_next = FRAME_IDLE;
  end

  // Frame controls; ncs edges win over any spck edge in the same cycle
  always_comb begin
    start_frame = ncs_fall;
    end_good    = 1'b0;
    end_bad     = 1'b0;
    take_bit    = 1'b0;
    give_bit    = 1'b0;
    if (state == FRAME_ACTIVE && !ncs_fall) begin
      if (ncs_rise) begin
        if (bit_cnt == CNT_W'(FRAME_W)) end_good = 1'b1;
        else                            end_bad  = 1'b1;
      end else begin
        take_bit = spck_rise;
        give_bit = spck_fall;
      end
    end
  end

  // Shift datapath, readback path and bad-frame counter
  always_ff @(posedge ck_1356meg) begin
    if (reset) begin
      shift         <= '0;
      bit_cnt       <= '0;
      tx            <= '0;
      rd_latch      <= '0;
      miso          <= 1'b0;
      frame_err_cnt <= '0;
    end else begin
      if (start_frame) begin
        shift    <= '0;
        bit_cnt  <= '0;
        tx       <= rd_latch;
        rd_latch <= '0;
      end
      if (take_bit) begin
        shift <= {shift[FRAME_W-2:0], mosi_sync};
        if (bit_cnt != CNT_W'(FRAME_W + 1)) bit_cnt <= bit_cnt + 1'b1;
      end
      if (give_bit) begin
        miso <= tx[FRAME_W-1];
        tx   <= {tx[FRAME_W-2:0], 1'b0};
      end
      if (end_good || end_bad) miso <= 1'b0;
      if (end_bad && frame_err_cnt != 8'hFF) frame_err_cnt <= frame_err_cnt + 8'd1;
      if (end_good) begin
        for (int k = 0; k < NUM_REGS; k++) begin
          if (cmd == CMD_W'(RD_BASE + k)) rd_latch <= {cmd, {PAD_W{1'b0}}, reg_q[k]};
        end
      end
    end
  end

  // Register writes, write strobes and the deferred major-mode commit
  always_ff @(posedge ck_1356meg) begin
    if (reset) begin
      for (int k = 0; k < NUM_REGS; k++) reg_q[k] <= (k == 0) ? REG0_RST : '0;
      wr_strobe    <= '0;
      pending_mode <= {MODE_W{1'b1}};
      mode_pending <= 1'b0;
      major_mode   <= {MODE_W{1'b1}};
      mode_changed <= 1'b0;
    end else begin
      wr_strobe    <= '0;
      mode_changed <= 1'b0;
      if (reg0_write) begin
        pending_mode <= dat[DATA_W-1 -: MODE_W];
        mode_pending <= 1'b1;
      end else if (mode_pending && mode_safe) begin
        major_mode   <= pending_mode;
        mode_pending <= 1'b0;
        mode_changed <= (pending_mode != major_mode);
      end
      if (end_good) begin
        for (int k = 0; k < NUM_REGS; k++) begin
          if (cmd == CMD_W'(k + 1)) begin
            reg_q[k]     <= dat;
            wr_strobe[k] <= 1'b1;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    assign regs[g*DATA_W +: DATA_W] = reg_q[g];
  end

endmodule
